muldiv_hilo_unit: RTL

- Multi-cycle MIPS multiply/divide unit that owns the architectural HI/LO registers.
- Takes register-file operands from the same read ports as the ALU, in parallel with it.
- Runs mult/multu/div/divu iteratively, one bit per cycle.
- Presents HI/LO continuously to the ALU result mux for mfhi/mflo.
- Pipeline control stalls on busy; mthi/mtlo write HI/LO directly.

---
 rtl/muldiv_hilo_if.sv | 30 +++
 rtl/muldiv_hilo_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_if.sv
// Pipeline-side bundle for the mul/div unit.
// The pipeline drives operands and HI/LO writes; the unit returns status and HI/LO.
interface muldiv_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] Read_data1;
  logic [WIDTH-1:0] Read_data2;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, Read_data1, Read_data2,
    output hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, Read_data1, Read_data2,
    input  hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative MIPS mult/multu/div/divu unit owning HI/LO.
// One bit per cycle over magnitudes; sign fix-up in the final state.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_hilo_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FINISH
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbzo_q, dbzo_d;

  logic             in_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx;
  logic [WIDTH-1:0] mul_lo_nx;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] div_hi_nx;
  logic [WIDTH-1:0] div_lo_nx;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               unused_bits;

  // Operand magnitudes and signs as seen at the start edge
  always_comb begin
    in_signed = ~bus.op[0];
    a_neg     = in_signed & bus.Read_data1[WIDTH-1];
    b_neg     = in_signed & bus.Read_data2[WIDTH-1];
    a_mag     = a_neg ? -bus.Read_data1 : bus.Read_data1;
    b_mag     = b_neg ? -bus.Read_data2 : bus.Read_data2;
  end

  // One shift-add step: HI accumulates, LO shifts out multiplier bits
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q}
              + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
  end

  // One restoring-divide step: HI is remainder, LO shifts dividend to quotient
  always_comb begin
    rem_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    rem_sub   = rem_sh - {1'b0, opb_q};
    rem_ge    = rem_sh >= {1'b0, opb_q};
    div_hi_nx = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    div_lo_nx = {acc_lo_q[WIDTH-2:0], rem_ge};
  end

  // Sign correction of the finished magnitude results
  always_comb begin
    prod        = {acc_hi_q, acc_lo_q};
    prod_fix    = neg_res_q ? -prod : prod;
    quo_fix     = neg_res_q ? -acc_lo_q : acc_lo_q;
    rem_fix     = neg_rem_q ? -acc_hi_q : acc_hi_q;
    unused_bits = rem_sub[WIDTH];
  end

  // Sequencer: launch in IDLE, iterate WIDTH times, commit HI/LO
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    rs_d      = rs_q;
    opb_d     = opb_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbzo_d    = dbzo_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.start) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          op_d      = bus.op;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dbz_d     = bus.op[1] & (bus.Read_data2 == '0);
          rs_d      = bus.Read_data1;
          opb_d     = b_mag;
          acc_hi_d  = '0;
          acc_lo_d  = a_mag;
          dbzo_d    = 1'b0;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q[1]) begin
          acc_hi_d = div_hi_nx;
          acc_lo_d = div_lo_nx;
        end else begin
          acc_hi_d = mul_hi_nx;
          acc_lo_d = mul_lo_nx;
        end
        if (cnt_q == LAST) state_d = S_FINISH;
      end
      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        dbzo_d  = op_q[1] & dbz_q;
        unique case (1'b1)
          !op_q[1]: begin
            {hi_d, lo_d} = prod_fix;
          end
          dbz_q: begin
            hi_d = rs_q;
            lo_d = '1;
          end
          default: begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        endcase
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      rs_q      <= '0;
      opb_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbzo_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      rs_q      <= rs_d;
      opb_q     <= opb_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbzo_q    <= dbzo_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbzo_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
